// File: rtl/run_ctrl_pkg.sv
// run_ctrl_pkg: shared state encoding and default timing constants for run_ctrl.
package run_ctrl_pkg;
  typedef enum logic [1:0] {
    PAUSE = 2'b00,
    RUN   = 2'b01,
    STEP  = 2'b10
  } run_state_t;
  localparam int unsigned RC_DEBOUNCE_DEFAULT = 1_000_000;
  localparam int unsigned RC_STEP_DEFAULT     = 2_500_000;
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-flop synchroniser, stability-count debouncer and rising-edge pulse.
module btn_debounce import run_ctrl_pkg::*; #(
  parameter int unsigned DEBOUNCE_CYCLES = RC_DEBOUNCE_DEFAULT
) (
  input  logic CLK,
  input  logic RST_N,
  input  logic din,
  output logic dout,
  output logic rise
);
  logic s1, s2, db_q;
  logic [31:0] cnt;
  // a change is taken only once the counter has already reached DEBOUNCE_CYCLES
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      s1   <= 1'b0;
      s2   <= 1'b0;
      db_q <= 1'b0;
      dout <= 1'b0;
      cnt  <= '0;
    end else begin
      s1   <= din;
      s2   <= s1;
      db_q <= dout;
      if (s2 == dout) cnt <= '0;
      else if (cnt == DEBOUNCE_CYCLES) begin
        dout <= s2;
        cnt  <= '0;
      end else cnt <= cnt + 32'd1;
    end
  end
  assign rise = dout & ~db_q;
endmodule

// File: rtl/run_ctrl.sv
// run_ctrl: debounced PAUSE/RUN/STEP control producing the CPU clock enable and speed select.
module run_ctrl import run_ctrl_pkg::*; #(
  parameter int unsigned DEBOUNCE_CYCLES = RC_DEBOUNCE_DEFAULT,
  parameter int unsigned STEP_CYCLES     = RC_STEP_DEFAULT
) (
  input  logic       CLK,
  input  logic       RST_N,
  input  logic       sw_speed,
  input  logic       btn_run,
  input  logic       btn_step,
  output logic       adjust,
  output logic       run_en,
  output logic [1:0] state_led
);
  logic speed_db, run_rise, step_rise;
  run_state_t state, nxt;
  logic [31:0] cnt, cnt_nxt;
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_speed (
    .CLK(CLK), .RST_N(RST_N), .din(sw_speed), .dout(speed_db), .rise()
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_run (
    .CLK(CLK), .RST_N(RST_N), .din(btn_run), .dout(), .rise(run_rise)
  );
  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_step (
    .CLK(CLK), .RST_N(RST_N), .din(btn_step), .dout(), .rise(step_rise)
  );
  // outside an active step the counter sits at the reload value, ready for entry
  always_comb begin
    nxt = state == PAUSE ? (run_rise ? RUN : step_rise ? STEP : PAUSE) :
          state == RUN   ? (run_rise ? PAUSE : RUN) :
          (state == STEP && cnt != '0) ? STEP : PAUSE;
    cnt_nxt = (state == STEP && cnt != '0) ? cnt - 32'd1 : STEP_CYCLES - 32'd1;
  end
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state  <= PAUSE;
      cnt    <= '0;
      run_en <= 1'b0;
      adjust <= 1'b0;
    end else begin
      state  <= nxt;
      cnt    <= cnt_nxt;
      run_en <= nxt == RUN || nxt == STEP;
      adjust <= speed_db;
    end
  end
  assign state_led = state;
endmodule

// File: tb/tb_run_ctrl.sv
// tb_run_ctrl: table-driven scoreboard bench for run_ctrl with DEBOUNCE_CYCLES=4, STEP_CYCLES=5.
module tb_run_ctrl;
  logic CLK = 1'b0;
  logic RST_N;
  logic sw_speed, btn_run, btn_step;
  logic adjust, run_en;
  logic [1:0] state_led;
  int checks = 0;
  int failures = 0;
  typedef struct {
    logic r, s, sp;
    int n;
    logic adj, ren;
    logic [1:0] led;
  } vec_t;
  typedef struct {
    logic adj, ren;
    logic [1:0] led;
    int id;
  } exp_t;
  vec_t tbl[$];
  exp_t sbq[$];
  exp_t e;
  run_ctrl #(.DEBOUNCE_CYCLES(4), .STEP_CYCLES(5)) dut (
    .CLK(CLK), .RST_N(RST_N), .sw_speed(sw_speed), .btn_run(btn_run),
    .btn_step(btn_step), .adjust(adjust), .run_en(run_en), .state_led(state_led)
  );
  always #5 CLK = ~CLK;
  task automatic add(input logic r, s, sp, input int n, input logic adj, ren, input logic [1:0] led);
    vec_t v;
    v.r = r; v.s = s; v.sp = sp; v.n = n; v.adj = adj; v.ren = ren; v.led = led;
    tbl.push_back(v);
  endtask
  task automatic cmp(input string nm, input int id, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[%0d] {adjust,run_en,state_led} got=%b want=%b", nm, id, act, exp);
    end
  endtask
  initial begin
    // idle
    add(0,0,0,3, 0,0,2'b00);
    // bouncing run press, then held: RUN on the 8th edge of the held level
    add(1,0,0,1, 0,0,2'b00);
    add(0,0,0,1, 0,0,2'b00);
    add(1,0,0,1, 0,0,2'b00);
    add(0,0,0,1, 0,0,2'b00);
    add(1,0,0,7, 0,0,2'b00);
    add(1,0,0,1, 0,1,2'b01);
    add(1,0,0,5, 0,1,2'b01);
    add(0,0,0,12,0,1,2'b01);
    add(1,0,0,7, 0,1,2'b01);
    add(1,0,0,1, 0,0,2'b00);
    add(0,0,0,12,0,0,2'b00);
    // clean single step: exactly 5 enabled cycles, held button does not retrigger
    add(0,1,0,7, 0,0,2'b00);
    add(0,1,0,1, 0,1,2'b10);
    add(0,1,0,4, 0,1,2'b10);
    add(0,1,0,1, 0,0,2'b00);
    add(0,1,0,5, 0,0,2'b00);
    add(0,0,0,12,0,0,2'b00);
    // run press landing inside a step is ignored
    add(0,1,0,1, 0,0,2'b00);
    add(1,1,0,6, 0,0,2'b00);
    add(1,1,0,1, 0,1,2'b10);
    add(1,1,0,4, 0,1,2'b10);
    add(1,1,0,1, 0,0,2'b00);
    add(1,1,0,4, 0,0,2'b00);
    add(0,0,0,12,0,0,2'b00);
    // simultaneous run and step: run wins
    add(1,1,0,7, 0,0,2'b00);
    add(1,1,0,1, 0,1,2'b01);
    add(1,1,0,6, 0,1,2'b01);
    add(0,0,0,12,0,1,2'b01);
    add(1,0,0,7, 0,1,2'b01);
    add(1,0,0,1, 0,0,2'b00);
    add(0,0,0,12,0,0,2'b00);
    // speed switch, then a 3-cycle glitch
    add(0,0,1,7, 0,0,2'b00);
    add(0,0,1,1, 1,0,2'b00);
    add(0,0,1,4, 1,0,2'b00);
    add(0,0,0,7, 1,0,2'b00);
    add(0,0,0,1, 0,0,2'b00);
    add(0,0,1,3, 0,0,2'b00);
    add(0,0,0,12,0,0,2'b00);
    RST_N = 1'b0;
    sw_speed = 1'b0;
    btn_run = 1'b0;
    btn_step = 1'b0;
    for (int c = 0; c < 8; c++) begin
      @(posedge CLK); #1;
      cmp("reset_hold", c, {adjust, run_en, state_led}, 4'b0000);
      sw_speed = 1'($urandom_range(0, 1));
      btn_run  = 1'($urandom_range(0, 1));
      btn_step = 1'($urandom_range(0, 1));
    end
    sw_speed = 1'b0;
    btn_run = 1'b0;
    btn_step = 1'b0;
    RST_N = 1'b1;
    foreach (tbl[i]) begin
      for (int c = 0; c < tbl[i].n; c++) begin
        btn_run = tbl[i].r;
        btn_step = tbl[i].s;
        sw_speed = tbl[i].sp;
        if (c == tbl[i].n - 1) begin
          e.adj = tbl[i].adj; e.ren = tbl[i].ren; e.led = tbl[i].led; e.id = i;
          sbq.push_back(e);
        end
        @(posedge CLK); #1;
        if (sbq.size() > 0) begin
          e = sbq.pop_front();
          cmp("vec", e.id, {adjust, run_en, state_led}, {e.adj, e.ren, e.led});
        end
      end
    end
    // reset in the middle of a step, with the step button still held
    btn_step = 1'b1;
    repeat (7) begin @(posedge CLK); #1; end
    @(posedge CLK); #1;
    cmp("step_entry", 0, {adjust, run_en, state_led}, 4'b0110);
    repeat (2) begin @(posedge CLK); #1; end
    cmp("step_cycle3", 0, {adjust, run_en, state_led}, 4'b0110);
    #2 RST_N = 1'b0;
    #1 cmp("async_reset", 0, {adjust, run_en, state_led}, 4'b0000);
    @(posedge CLK); @(posedge CLK); #1;
    RST_N = 1'b1;
    for (int c = 0; c < 6; c++) begin
      @(posedge CLK); #1;
      cmp("post_reset", c, {adjust, run_en, state_led}, 4'b0000);
    end
    btn_step = 1'b0;
    repeat (20) @(posedge CLK);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
